// File: rtl/sound_event_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sound_event_scheduler: prioritised, preemptive sequencer for game tones. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sound_event_scheduler #(
  parameter int MOVE_CYCLES    = 1500000,
  parameter int HIT_CYCLES     = 4000000,
  parameter int VICTORY_CYCLES = 50000000,
  parameter int GAP_CYCLES     = 250000,
  parameter int CNT_W          = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_move,
  input  logic       req_hit,
  input  logic       req_victory,
  input  logic       mute,
  output logic [1:0] tone_select,
  output logic       tone_en,
  output logic       busy,
  output logic [7:0] merge_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [1:0] CLS_MOVE = 2'd0;
  localparam logic [1:0] CLS_HIT  = 2'd1;
  localparam logic [1:0] CLS_VIC  = 2'd2;

  localparam logic [CNT_W-1:0] MOVE_LOAD    = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIT_LOAD     = CNT_W'(HIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] VICTORY_LOAD = CNT_W'(VICTORY_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pend_q, pend_d;
  logic [1:0]       sel_q, sel_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic [7:0]       merge_q, merge_d;

  logic [2:0] req_v, cand, pend_set, pend_clr, merged;
  logic [1:0] cand_cls, req_cls;
  logic       do_arb;
  logic [8:0] merge_sum;

  function automatic logic [1:0] top_cls(input logic [2:0] v);
    if (v[2]) return CLS_VIC;
    if (v[1]) return CLS_HIT;
    return CLS_MOVE;
  endfunction

  function automatic logic [CNT_W-1:0] dur_load(input logic [1:0] cls);
    case (cls)
      CLS_VIC: return VICTORY_LOAD;
      CLS_HIT: return HIT_LOAD;
      default: return MOVE_LOAD;
    endcase
  endfunction

  function automatic logic [2:0] cls_oh(input logic [1:0] cls);
    return 3'b001 << cls;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    en_d      = en_q;
    pend_d    = pend_q;
    merge_d   = merge_q;
    req_v     = {req_victory, req_hit, req_move};
    cand      = req_v | pend_q;
    cand_cls  = top_cls(cand);
    req_cls   = top_cls(req_v);
    pend_set  = 3'b000;
    pend_clr  = 3'b000;
    merged    = 3'b000;
    merge_sum = 9'd0;
    do_arb    = 1'b0;

    if (mute) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
      pend_d  = 3'b000;
    end else begin
      case (state_q)
        ST_IDLE: do_arb = 1'b1;
        ST_PLAY: begin
          // Preempt and retrigger outrank expiry in the same cycle.
          if ((req_v != 3'b000) && (req_cls > sel_q)) begin
            sel_d    = req_cls;
            cnt_d    = dur_load(req_cls);
            pend_set = req_v & ~cls_oh(req_cls);
          end else if ((req_v & cls_oh(sel_q)) != 3'b000) begin
            cnt_d    = dur_load(sel_q);
            pend_set = req_v & ~cls_oh(sel_q);
          end else if (cnt_q == '0) begin
            if (GAP_CYCLES > 0) begin
              state_d  = ST_GAP;
              cnt_d    = GAP_LOAD;
              en_d     = 1'b0;
              pend_set = req_v;
            end else begin
              do_arb = 1'b1;
            end
          end else begin
            cnt_d    = cnt_q - CNT_W'(1);
            pend_set = req_v;
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            do_arb = 1'b1;
          end else begin
            cnt_d    = cnt_q - CNT_W'(1);
            pend_set = req_v;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (do_arb) begin
        if (cand != 3'b000) begin
          state_d  = ST_PLAY;
          sel_d    = cand_cls;
          cnt_d    = dur_load(cand_cls);
          en_d     = 1'b1;
          pend_clr = cls_oh(cand_cls);
          pend_set = req_v & ~pend_clr;
        end else begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
        end
      end

      merged    = pend_set & pend_q;
      pend_d    = (pend_q & ~pend_clr) | pend_set;
      merge_sum = {1'b0, merge_q} + 9'(merged[0]) + 9'(merged[1]) + 9'(merged[2]);
      merge_d   = merge_sum[8] ? 8'hFF : merge_sum[7:0];
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 3'b000;
      sel_q   <= CLS_MOVE;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      merge_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      merge_q <= merge_d;
    end
  end

  assign tone_select = sel_q;
  assign tone_en     = en_q;
  assign busy        = busy_q;
  assign merge_cnt   = merge_q;

endmodule
`default_nettype wire

// File: tb/tb_sound_event_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sound_event_scheduler: directed self-checking bench for the scheduler.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sound_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_move = 1'b0;
  logic       req_hit = 1'b0;
  logic       req_victory = 1'b0;
  logic       mute = 1'b0;
  logic [1:0] tone_select;
  logic       tone_en;
  logic       busy;
  logic [7:0] merge_cnt;

  int errors = 0;
  int checks = 0;

  sound_event_scheduler #(
    .MOVE_CYCLES   (4),
    .HIT_CYCLES    (6),
    .VICTORY_CYCLES(10),
    .GAP_CYCLES    (2),
    .CNT_W         (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_move   (req_move),
    .req_hit    (req_hit),
    .req_victory(req_victory),
    .mute       (mute),
    .tone_select(tone_select),
    .tone_en    (tone_en),
    .busy       (busy),
    .merge_cnt  (merge_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req_move = 1'b0; req_hit = 1'b0; req_victory = 1'b0; mute = 1'b0;
    @(negedge clk);
    checks++;
    if (tone_en !== 1'b0 || busy !== 1'b0 || tone_select !== 2'b00 || merge_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset: en=%b busy=%b sel=%b merge=%0d, expected 0 0 00 0",
               tone_en, busy, tone_select, merge_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_hit();
    logic e_en, e_busy;
    req_hit = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      req_hit = 1'b0;
      e_en = (k <= 6); e_busy = (k <= 8);
      checks++;
      if (tone_en !== e_en || busy !== e_busy || tone_select !== 2'b01) begin
        errors++;
        $display("FAIL single_hit k=%0d: en=%b busy=%b sel=%b, expected en=%b busy=%b sel=01",
                 k, tone_en, busy, tone_select, e_en, e_busy);
      end
    end
  endtask

  task automatic test_preempt();
    logic e_en, e_busy; logic [1:0] e_sel;
    req_move = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req_move = 1'b0;
      e_en = (k <= 12); e_busy = (k <= 14); e_sel = (k <= 2) ? 2'b00 : 2'b10;
      checks++;
      if (tone_en !== e_en || busy !== e_busy || tone_select !== e_sel) begin
        errors++;
        $display("FAIL preempt k=%0d: en=%b busy=%b sel=%b, expected en=%b busy=%b sel=%b",
                 k, tone_en, busy, tone_select, e_en, e_busy, e_sel);
      end
      req_victory = (k == 2);
    end
  endtask

  task automatic test_merge();
    logic e_en, e_busy; logic [1:0] e_sel;
    req_victory = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      req_victory = 1'b0;
      e_en = (k <= 10) || (k >= 13 && k <= 16);
      e_busy = (k <= 18);
      e_sel = (k <= 12) ? 2'b10 : 2'b00;
      checks++;
      if (tone_en !== e_en || busy !== e_busy || tone_select !== e_sel) begin
        errors++;
        $display("FAIL merge k=%0d: en=%b busy=%b sel=%b, expected en=%b busy=%b sel=%b",
                 k, tone_en, busy, tone_select, e_en, e_busy, e_sel);
      end
      req_move = (k == 3) || (k == 6);
    end
    checks++;
    if (merge_cnt !== 8'd1) begin
      errors++;
      $display("FAIL merge_cnt: got %0d, expected 1", merge_cnt);
    end
  endtask

  task automatic test_simultaneous();
    logic e_en, e_busy; logic [1:0] e_sel;
    req_move = 1'b1; req_hit = 1'b1; req_victory = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      req_move = 1'b0; req_hit = 1'b0; req_victory = 1'b0;
      e_en = (k <= 10) || (k >= 13 && k <= 18) || (k >= 21 && k <= 24);
      e_busy = (k <= 26);
      e_sel = (k <= 12) ? 2'b10 : (k <= 20) ? 2'b01 : 2'b00;
      checks++;
      if (tone_en !== e_en || busy !== e_busy || tone_select !== e_sel) begin
        errors++;
        $display("FAIL simultaneous k=%0d: en=%b busy=%b sel=%b, expected en=%b busy=%b sel=%b",
                 k, tone_en, busy, tone_select, e_en, e_busy, e_sel);
      end
    end
    checks++;
    if (merge_cnt !== 8'd0) begin
      errors++;
      $display("FAIL simultaneous merge_cnt: got %0d, expected 0", merge_cnt);
    end
  endtask

  task automatic test_retrigger();
    logic e_en, e_busy;
    int   high = 0;
    req_move = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      req_move = 1'b0;
      if (tone_en === 1'b1) high++;
      e_en = (k <= 7); e_busy = (k <= 9);
      checks++;
      if (tone_en !== e_en || busy !== e_busy || tone_select !== 2'b00) begin
        errors++;
        $display("FAIL retrigger k=%0d: en=%b busy=%b sel=%b, expected en=%b busy=%b sel=00",
                 k, tone_en, busy, tone_select, e_en, e_busy);
      end
      req_move = (k == 3);
    end
    checks++;
    if (high != 7) begin
      errors++;
      $display("FAIL retrigger_len: tone_en high %0d cycles, expected 7", high);
    end
  endtask

  task automatic test_mute();
    logic e_en, e_busy;
    req_hit = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req_hit = 1'b0; req_move = 1'b0;
      e_en = (k <= 3); e_busy = (k <= 3);
      checks++;
      if (tone_en !== e_en || busy !== e_busy || tone_select !== 2'b01) begin
        errors++;
        $display("FAIL mute k=%0d: en=%b busy=%b sel=%b, expected en=%b busy=%b sel=01",
                 k, tone_en, busy, tone_select, e_en, e_busy);
      end
      if (k == 2) req_move = 1'b1;
      if (k == 3) mute = 1'b1;
      if (k == 4) begin req_move = 1'b1; req_hit = 1'b1; end
      if (k == 6) mute = 1'b0;
    end
    checks++;
    if (merge_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mute merge_cnt: got %0d, expected 0", merge_cnt);
    end
  endtask

  task automatic test_async_reset();
    req_victory = 1'b1;
    @(negedge clk);
    req_victory = 1'b0;
    @(negedge clk);
    checks++;
    if (tone_en !== 1'b1 || tone_select !== 2'b10) begin
      errors++;
      $display("FAIL async_pre: en=%b sel=%b, expected en=1 sel=10", tone_en, tone_select);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tone_en !== 1'b0 || busy !== 1'b0 || tone_select !== 2'b00 || merge_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: en=%b busy=%b sel=%b merge=%0d, expected 0 0 00 0",
               tone_en, busy, tone_select, merge_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_reset();
    test_preempt();
    test_reset();
    test_merge();
    test_reset();
    test_simultaneous();
    test_reset();
    test_retrigger();
    test_reset();
    test_mute();
    test_reset();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
